// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: accepts one note event at a time, scans every voice once,
// then commits a retrigger / lowest-free / steal-oldest assignment to the oscillator bank.
module midi_voice_allocator #(
    parameter int NUM_VOICES = 8,
    parameter int AGE_W      = 8
) (
    input  logic                    clk_100mhz,
    input  logic                    rst_in,
    input  logic                    ev_valid,
    output logic                    ev_ready,
    input  logic                    ev_on,
    input  logic [6:0]              ev_note,
    input  logic [6:0]              ev_vel,
    input  logic                    panic,
    output logic [NUM_VOICES-1:0]   voice_active,
    output logic [7*NUM_VOICES-1:0] voice_note,
    output logic [7*NUM_VOICES-1:0] voice_vel,
    output logic [NUM_VOICES-1:0]   voice_trig,
    output logic [NUM_VOICES-1:0]   voice_release,
    output logic                    steal
);
    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [AGE_W-1:0] AGE_MAX  = {AGE_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  ready_q, ready_d;
    logic                  ev_on_q, ev_on_d;
    logic [6:0]            ev_note_q, ev_note_d;
    logic [6:0]            ev_vel_q, ev_vel_d;
    logic [IDX_W-1:0]      scan_idx_q, scan_idx_d;
    logic                  match_hit_q, match_hit_d;
    logic                  free_hit_q, free_hit_d;
    logic                  old_hit_q, old_hit_d;
    logic [IDX_W-1:0]      match_idx_q, match_idx_d;
    logic [IDX_W-1:0]      free_idx_q, free_idx_d;
    logic [IDX_W-1:0]      old_idx_q, old_idx_d;
    logic [AGE_W-1:0]      old_age_q, old_age_d;
    logic [NUM_VOICES-1:0] active_q, active_d;
    logic [NUM_VOICES-1:0] trig_q, trig_d;
    logic [NUM_VOICES-1:0] rel_q, rel_d;
    logic                  steal_q, steal_d;
    logic [6:0]            note_q [NUM_VOICES];
    logic [6:0]            note_d [NUM_VOICES];
    logic [6:0]            vel_q  [NUM_VOICES];
    logic [6:0]            vel_d  [NUM_VOICES];
    logic [AGE_W-1:0]      age_q  [NUM_VOICES];
    logic [AGE_W-1:0]      age_d  [NUM_VOICES];

    logic                  cur_match_s, cur_free_s, cur_old_s;
    logic [IDX_W-1:0]      target_s;

    // Next-state and next-voice computation; panic overrides every state.
    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        ev_on_d     = ev_on_q;
        ev_note_d   = ev_note_q;
        ev_vel_d    = ev_vel_q;
        scan_idx_d  = scan_idx_q;
        match_hit_d = match_hit_q;
        free_hit_d  = free_hit_q;
        old_hit_d   = old_hit_q;
        match_idx_d = match_idx_q;
        free_idx_d  = free_idx_q;
        old_idx_d   = old_idx_q;
        old_age_d   = old_age_q;
        active_d    = active_q;
        note_d      = note_q;
        vel_d       = vel_q;
        age_d       = age_q;
        trig_d      = {NUM_VOICES{1'b0}};
        rel_d       = {NUM_VOICES{1'b0}};
        steal_d     = 1'b0;
        target_s    = {IDX_W{1'b0}};
        cur_match_s = 1'b0;
        cur_free_s  = 1'b0;
        cur_old_s   = 1'b0;

        if (panic) begin
            state_d  = IDLE;
            ready_d  = 1'b1;
            rel_d    = active_q;
            active_d = {NUM_VOICES{1'b0}};
            for (int i = 0; i < NUM_VOICES; i++) begin
                age_d[i] = {AGE_W{1'b0}};
            end
        end else begin
            case (state_q)
                IDLE: begin
                    ready_d = 1'b1;
                    if (ev_valid && ready_q) begin
                        state_d     = SCAN;
                        ready_d     = 1'b0;
                        ev_on_d     = ev_on && (ev_vel != 7'd0);
                        ev_note_d   = ev_note;
                        ev_vel_d    = ev_vel;
                        scan_idx_d  = {IDX_W{1'b0}};
                        match_hit_d = 1'b0;
                        free_hit_d  = 1'b0;
                        old_hit_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                SCAN: begin
                    // Each tracker latches only its first qualifying voice, which gives lowest-index ties.
                    cur_match_s = active_q[scan_idx_q] && (note_q[scan_idx_q] == ev_note_q) && !match_hit_q;
                    cur_free_s  = !active_q[scan_idx_q] && !free_hit_q;
                    cur_old_s   = active_q[scan_idx_q] && (!old_hit_q || (age_q[scan_idx_q] > old_age_q));
                    match_hit_d = match_hit_q | cur_match_s;
                    match_idx_d = cur_match_s ? scan_idx_q : match_idx_q;
                    free_hit_d  = free_hit_q | cur_free_s;
                    free_idx_d  = cur_free_s ? scan_idx_q : free_idx_q;
                    old_hit_d   = old_hit_q | cur_old_s;
                    old_idx_d   = cur_old_s ? scan_idx_q : old_idx_q;
                    old_age_d   = cur_old_s ? age_q[scan_idx_q] : old_age_q;
                    if (scan_idx_q == LAST_IDX) begin
                        state_d = COMMIT;
                    end else begin
                        scan_idx_d = scan_idx_q + 1'b1;
                    end
                end
                COMMIT: begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    if (ev_on_q) begin
                        target_s = match_hit_q ? match_idx_q : (free_hit_q ? free_idx_q : old_idx_q);
                        steal_d  = !match_hit_q && !free_hit_q;
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (IDX_W'(i) == target_s) begin
                                active_d[i] = 1'b1;
                                note_d[i]   = ev_note_q;
                                vel_d[i]    = ev_vel_q;
                                age_d[i]    = {AGE_W{1'b0}};
                                trig_d[i]   = 1'b1;
                            end else if (active_q[i] && (age_q[i] != AGE_MAX)) begin
                                age_d[i] = age_q[i] + 1'b1;
                            end else begin
                                age_d[i] = age_q[i];
                            end
                        end
                    end else if (match_hit_q) begin
                        // Note and velocity stay put so the envelope can finish its release.
                        active_d[match_idx_q] = 1'b0;
                        age_d[match_idx_q]    = {AGE_W{1'b0}};
                        rel_d[match_idx_q]    = 1'b1;
                    end else begin
                        active_d = active_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                    ready_d = 1'b0;
                end
            endcase
        end
    end

    // State, event capture, scan trackers and voice registers.
    always_ff @(posedge clk_100mhz or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            ev_on_q     <= 1'b0;
            ev_note_q   <= 7'd0;
            ev_vel_q    <= 7'd0;
            scan_idx_q  <= {IDX_W{1'b0}};
            match_hit_q <= 1'b0;
            free_hit_q  <= 1'b0;
            old_hit_q   <= 1'b0;
            match_idx_q <= {IDX_W{1'b0}};
            free_idx_q  <= {IDX_W{1'b0}};
            old_idx_q   <= {IDX_W{1'b0}};
            old_age_q   <= {AGE_W{1'b0}};
            active_q    <= {NUM_VOICES{1'b0}};
            trig_q      <= {NUM_VOICES{1'b0}};
            rel_q       <= {NUM_VOICES{1'b0}};
            steal_q     <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= 7'd0;
                vel_q[i]  <= 7'd0;
                age_q[i]  <= {AGE_W{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            ev_on_q     <= ev_on_d;
            ev_note_q   <= ev_note_d;
            ev_vel_q    <= ev_vel_d;
            scan_idx_q  <= scan_idx_d;
            match_hit_q <= match_hit_d;
            free_hit_q  <= free_hit_d;
            old_hit_q   <= old_hit_d;
            match_idx_q <= match_idx_d;
            free_idx_q  <= free_idx_d;
            old_idx_q   <= old_idx_d;
            old_age_q   <= old_age_d;
            active_q    <= active_d;
            trig_q      <= trig_d;
            rel_q       <= rel_d;
            steal_q     <= steal_d;
            note_q      <= note_d;
            vel_q       <= vel_d;
            age_q       <= age_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_VOICES; g++) begin : g_pack
            assign voice_note[7*g +: 7] = note_q[g];
            assign voice_vel[7*g +: 7]  = vel_q[g];
        end
    endgenerate

    assign ev_ready      = ready_q;
    assign voice_active  = active_q;
    assign voice_trig    = trig_q;
    assign voice_release = rel_q;
    assign steal         = steal_q;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Bench for midi_voice_allocator: directed scenarios plus random note traffic, scored
// against a timestamp-based voice model through an expected-result queue.
module tb_midi_voice_allocator;
    localparam int NV      = 4;
    localparam int AW      = 8;
    localparam int AGE_SAT = (1 << AW) - 1;

    logic            clk_100mhz = 1'b0;
    logic            rst_in     = 1'b1;
    logic            ev_valid   = 1'b0;
    logic            ev_on      = 1'b0;
    logic [6:0]      ev_note    = 7'd0;
    logic [6:0]      ev_vel     = 7'd0;
    logic            panic      = 1'b0;
    logic            ev_ready;
    logic [NV-1:0]   voice_active;
    logic [7*NV-1:0] voice_note;
    logic [7*NV-1:0] voice_vel;
    logic [NV-1:0]   voice_trig;
    logic [NV-1:0]   voice_release;
    logic            steal;

    midi_voice_allocator #(.NUM_VOICES(NV), .AGE_W(AW)) dut (
        .clk_100mhz   (clk_100mhz),
        .rst_in       (rst_in),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_on        (ev_on),
        .ev_note      (ev_note),
        .ev_vel       (ev_vel),
        .panic        (panic),
        .voice_active (voice_active),
        .voice_note   (voice_note),
        .voice_vel    (voice_vel),
        .voice_trig   (voice_trig),
        .voice_release(voice_release),
        .steal        (steal)
    );

    typedef struct {
        logic [NV-1:0]   act;
        logic [7*NV-1:0] note;
        logic [7*NV-1:0] vel;
        logic [NV-1:0]   trig;
        logic [NV-1:0]   rel;
        logic            stl;
        int              done;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    logic prev_rdy = 1'b0;

    // Model: a voice's age is the number of note-on commits since it was last triggered.
    bit   m_act  [NV];
    int   m_note [NV];
    int   m_vel  [NV];
    int   m_stamp[NV];
    int   non_cnt = 0;

    always #5 clk_100mhz = ~clk_100mhz;

    always @(posedge clk_100mhz) cyc++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.act = '0; e.note = '0; e.vel = '0; e.trig = '0; e.rel = '0; e.stl = 1'b0; e.done = -1;
        for (int i = 0; i < NV; i++) begin
            e.act[i]         = m_act[i];
            e.note[7*i +: 7] = 7'(m_note[i]);
            e.vel[7*i +: 7]  = 7'(m_vel[i]);
        end
        return e;
    endfunction

    function automatic exp_t model_event(input bit on, input int note, input int vel);
        int   match = -1;
        int   free  = -1;
        int   tgt   = -1;
        int   best  = -1;
        int   a;
        exp_t e;
        for (int i = 0; i < NV; i++) begin
            if (m_act[i] && m_note[i] == note && match < 0) match = i;
            if (!m_act[i] && free < 0) free = i;
        end
        if (on && vel != 0) begin
            if (match >= 0) tgt = match;
            else if (free >= 0) tgt = free;
            else begin
                for (int i = 0; i < NV; i++) begin
                    a = non_cnt - m_stamp[i];
                    if (a > AGE_SAT) a = AGE_SAT;
                    if (m_act[i] && a > best) begin best = a; tgt = i; end
                end
            end
            non_cnt++;
            m_act[tgt] = 1'b1; m_note[tgt] = note; m_vel[tgt] = vel; m_stamp[tgt] = non_cnt;
            e = snap();
            e.trig[tgt] = 1'b1;
            e.stl = (match < 0) && (free < 0);
        end else begin
            if (match >= 0) m_act[match] = 1'b0;
            e = snap();
            if (match >= 0) e.rel[match] = 1'b1;
        end
        return e;
    endfunction

    function automatic exp_t model_panic();
        exp_t e;
        logic [NV-1:0] was = '0;
        for (int i = 0; i < NV; i++) begin was[i] = m_act[i]; m_act[i] = 1'b0; end
        e = snap();
        e.rel = was;
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_act[i] = 1'b0; m_note[i] = 0; m_vel[i] = 0; m_stamp[i] = 0;
        end
    endtask

    // Monitor: an ev_ready rise marks a completed event, panic or reset; otherwise outputs must hold.
    always @(negedge clk_100mhz) begin
        if (rst_in) begin
            prev_rdy = 1'b0;
            model_reset_cur();
        end else begin
            if (!prev_rdy && ev_ready) begin
                if (sb_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_done: ev_ready rose with no event outstanding");
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("active", voice_active, mon_e.act);
                    chk("note", voice_note, mon_e.note);
                    chk("vel", voice_vel, mon_e.vel);
                    chk("trig", voice_trig, mon_e.trig);
                    chk("release", voice_release, mon_e.rel);
                    chk("steal", steal, mon_e.stl);
                    if (mon_e.done >= 0) chk("latency", cyc, mon_e.done);
                    cur = mon_e;
                    cur.trig = '0; cur.rel = '0; cur.stl = 1'b0;
                end
            end else begin
                chk("hold", {voice_active, voice_trig, voice_release, steal, voice_note, voice_vel},
                    {cur.act, cur.trig, cur.rel, cur.stl, cur.note, cur.vel});
            end
            prev_rdy = ev_ready;
        end
    end

    task automatic model_reset_cur();
        cur.act = '0; cur.note = '0; cur.vel = '0; cur.trig = '0; cur.rel = '0; cur.stl = 1'b0; cur.done = -1;
    endtask

    task automatic apply_reset(input bit chk_now);
        exp_t e;
        rst_in = 1'b1;
        sb_q.delete();
        model_reset();
        if (chk_now) begin
            #1;
            chk("async_reset", {ev_ready, voice_active, voice_trig, voice_release, steal, voice_note, voice_vel}, 128'd0);
        end
        repeat (2) @(posedge clk_100mhz);
        #2;
        rst_in = 1'b0;
        e = snap();
        e.done = cyc + 1;
        sb_q.push_back(e);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_100mhz);
            if (ev_ready) return;
        end
        n_total++;
        $display("FAIL ready_timeout: ev_ready=0 after 50 cycles, required 1");
    endtask

    // abort_kind: 0 none, 1 panic on edge abort_at after accept, 2 reset after abort_at edges.
    task automatic send_event(input bit on, input int note, input int vel, input int abort_kind, input int abort_at);
        exp_t e;
        bit   ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk_100mhz);
            if (ev_ready) ok = 1'b1;
        end
        if (!ok) begin
            n_total++;
            $display("FAIL send_timeout: ev_ready=0 after 50 cycles, required 1");
            return;
        end
        ev_valid = 1'b1; ev_on = on; ev_note = 7'(note); ev_vel = 7'(vel);
        @(posedge clk_100mhz);
        #1;
        ev_valid = 1'b0; ev_on = 1'($urandom); ev_note = 7'($urandom); ev_vel = 7'($urandom);
        if (abort_kind == 0) begin
            e = model_event(on, note, vel);
            e.done = cyc + NV + 1;
            sb_q.push_back(e);
        end else if (abort_kind == 1) begin
            repeat (abort_at - 1) @(posedge clk_100mhz);
            @(negedge clk_100mhz);
            panic = 1'b1;
            @(posedge clk_100mhz);
            #1;
            panic = 1'b0;
            e = model_panic();
            e.done = cyc;
            sb_q.push_back(e);
        end else begin
            repeat (abort_at) @(posedge clk_100mhz);
            #1;
            apply_reset(1'b1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset_cur();
        apply_reset(1'b0);
        wait_ready();

        send_event(1'b1, 60, 100, 0, 0);
        wait_ready();
        chk("t1_active", voice_active, 4'b0001);
        chk("t1_note0", voice_note[6:0], 7'd60);
        chk("t1_vel0", voice_vel[6:0], 7'd100);
        chk("t1_trig", voice_trig, 4'b0001);

        send_event(1'b1, 62, 100, 0, 0);
        send_event(1'b1, 64, 100, 0, 0);
        send_event(1'b1, 67, 100, 0, 0);
        send_event(1'b1, 72, 100, 0, 0);
        wait_ready();
        chk("t2_steal", steal, 1'b1);
        chk("t2_trig", voice_trig, 4'b0001);
        chk("t2_note0", voice_note[6:0], 7'd72);

        send_event(1'b0, 62, 0, 0, 0);
        wait_ready();
        chk("t3_release", voice_release, 4'b0010);
        chk("t3_active", voice_active, 4'b1101);
        send_event(1'b1, 70, 80, 0, 0);
        wait_ready();
        chk("t3_trig", voice_trig, 4'b0010);
        chk("t3_steal", steal, 1'b0);

        @(posedge clk_100mhz); #2;
        apply_reset(1'b1);
        send_event(1'b1, 60, 100, 0, 0);
        send_event(1'b1, 60, 50, 0, 0);
        wait_ready();
        chk("t4_active", voice_active, 4'b0001);
        chk("t4_vel0", voice_vel[6:0], 7'd50);
        chk("t4_steal", steal, 1'b0);
        send_event(1'b1, 60, 0, 0, 0);
        wait_ready();
        chk("t4_release", voice_release, 4'b0001);
        chk("t4_active_off", voice_active, 4'b0000);

        send_event(1'b1, 61, 10, 0, 0);
        send_event(1'b0, 99, 20, 0, 0);
        wait_ready();
        chk("t5_pulses", {voice_trig, voice_release, steal}, 9'd0);
        chk("t5_active", voice_active, 4'b0001);

        send_event(1'b1, 63, 30, 0, 0);
        send_event(1'b1, 65, 90, 1, 2);
        wait_ready();
        chk("t6_release", voice_release, 4'b0011);
        chk("t6_active", voice_active, 4'b0000);
        send_event(1'b1, 61, 10, 0, 0);
        send_event(1'b1, 63, 30, 0, 0);
        send_event(1'b1, 65, 90, 2, 3);
        wait_ready();

        send_event(1'b1, 60, 11, 0, 0);
        send_event(1'b1, 62, 12, 0, 0);
        send_event(1'b1, 64, 13, 0, 0);
        send_event(1'b1, 67, 14, 0, 0);
        send_event(1'b1, 60, 15, 0, 0);
        for (int i = 0; i < 300; i++) send_event(1'b1, 67, 1 + (i % 127), 0, 0);
        send_event(1'b1, 80, 40, 0, 0);
        wait_ready();
        chk("sat_trig", voice_trig, 4'b0001);
        chk("sat_steal", steal, 1'b1);

        for (int n = 0; n < 200; n++) begin
            int r;
            int vel;
            r   = $urandom_range(0, 19);
            vel = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 127);
            if (r == 0)
                send_event($urandom_range(0, 99) < 65, 60 + $urandom_range(0, 7), vel, 1, $urandom_range(1, NV + 1));
            else if (r == 1)
                send_event($urandom_range(0, 99) < 65, 60 + $urandom_range(0, 7), vel, 2, $urandom_range(1, NV));
            else
                send_event($urandom_range(0, 99) < 65, 60 + $urandom_range(0, 7), vel, 0, 0);
        end
        wait_ready();
        repeat (3) @(negedge clk_100mhz);
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/midi_voice_allocator.md
Name: midi_voice_allocator

Overview:
- Polyphonic voice scheduler between the MIDI processor (note events) and the oscillator bank (NUM_VOICES voices).
- Accepts note-on/note-off events over a valid/ready handshake and assigns each event to one voice slot.
- Assignment priority: retrigger the same note, then the lowest free voice, then steal the oldest voice.
- Drives per-voice note, velocity, active, trigger and release signals consumed by the oscillators/envelopes.

Parameters:
- NUM_VOICES, 8: number of oscillator voices; ≥2, power of two not required.
- AGE_W, 8: width of the per-voice saturating age counter.

Ports:
- clk_100mhz  in  1  system clock
- rst_in  in  1  asynchronous active-high reset
- ev_valid  in  1  note event valid
- ev_ready  out  1  allocator can accept an event
- ev_on  in  1  1 = note-on, 0 = note-off
- ev_note  in  7  MIDI note number
- ev_vel  in  7  MIDI velocity
- panic  in  1  one-cycle all-notes-off request
- voice_active  out  NUM_VOICES  voice currently holds a note
- voice_note  out  7*NUM_VOICES  note per voice; voice i occupies bits [7i+6:7i]
- voice_vel  out  7*NUM_VOICES  velocity per voice, same packing
- voice_trig  out  NUM_VOICES  one-cycle pulse: voice (re)started
- voice_release  out  NUM_VOICES  one-cycle pulse: voice released
- steal  out  1  one-cycle pulse: the last note-on stole an active voice

Behaviour:
- Reset (asynchronous, any time, including mid-scan): all outputs 0, all ages 0, FSM=IDLE, in-flight event discarded. ev_ready goes to 1 on the first clock edge after rst_in deasserts.
- Handshake: an event is accepted on a clock edge where ev_valid && ev_ready. ev_on, ev_note and ev_vel are captured at that edge. ev_ready is registered and drops to 0 on the accept edge.
- Normalisation: a note-on with ev_vel == 0 is treated as a note-off.
- FSM states:
  - IDLE -> SCAN on accept.
  - SCAN lasts NUM_VOICES cycles, examining voice i in scan cycle i. It tracks:
    - first match: the lowest i with active && note == ev_note;
    - first free: the lowest inactive i;
    - oldest: the maximum age among active voices, ties going to the lowest index.
  - SCAN -> COMMIT -> IDLE.
- Timing: if the accept edge is E0, voice outputs update and pulses are asserted after edge E0+NUM_VOICES+1. ev_ready returns to 1 at that same edge. Throughput is one event per NUM_VOICES+2 cycles.
- Note-on commit:
  - Target voice is the match if one exists, else the first free voice, else the oldest voice (steal=1).
  - Target voice gets note, vel, active=1 and age=0, plus a voice_trig pulse.
  - Every other active voice increments its age, saturating at 2^AGE_W-1.
  - A retrigger of the same note is not a steal.
- Note-off commit:
  - If a match exists: voice active=0, age=0, voice_release pulse. voice_note and voice_vel hold their last values for the envelope release.
  - If no match: no state change and no pulse.
- Pulses (voice_trig, voice_release, steal) last exactly one cycle. At most one voice_trig bit is set per commit.
- panic:
  - Sampled every cycle and takes priority over everything else.
  - On the next edge: all voice_active=0, all ages=0, voice_release pulses for every voice that was active, FSM=IDLE, ev_ready=1.
  - Any in-flight event is discarded. An event handshaking in the same cycle as panic is also discarded.
  - panic asserted in the same cycle as COMMIT discards the commit.
- Voice state changes only in COMMIT or on panic/reset, never during SCAN.

Test Plan (NUM_VOICES=4, AGE_W=8):
- Reset, then note-on 60/vel 100 -> after 5 cycles voice 0: active=1, note=60, vel=100; voice_trig=4'b0001 for 1 cycle; ev_ready high again.
- Note-on 60, 62, 64, 67, then note-on 72 -> voices 0–3 filled in order; 72 steals voice 0 (oldest, age 3); steal=1; voice_trig=4'b0001; voice 0 note=72.
- Voices 0–3 hold 60, 62, 64, 67; note-off 62 -> voice_release=4'b0010, voice 1 active=0; next note-on 70 goes to voice 1 with steal=0.
- Note-on 60/vel 100, then note-on 60/vel 50 -> same voice 0 retriggered; vel=50; steal=0; voice 1 remains inactive. Then note-on 60/vel 0 -> voice 0 released.
- Note-off 99 with no match -> no pulses, outputs unchanged, ev_ready restored after 5 cycles.
- Two voices active, panic mid-SCAN of a note-on -> release pulse on both voices, all inactive, event dropped. Repeat with rst_in asserted mid-SCAN -> all outputs 0 immediately (asynchronous).
